// File: rtl/image_buffer_pkg.sv
// Shared image geometry and buffer state encoding for the SPI receive path,
// the top-level FSM, the BNN core and debug monitoring.
package image_pkg;

    localparam int IMG_W      = 30;
    localparam int IMG_H      = 30;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int BYTE_W     = 8;
    localparam int IMG_BITS   = 904;
    localparam int IMG_BYTES  = IMG_BITS / BYTE_W;
    localparam int ADDR_W     = 10;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/image_buffer.sv
// Packs the SPI byte stream into a flat 904-bit image and holds it for the BNN.
// Optional running byte checksum is enabled by defining IMAGE_BUFFER_CHECKSUM_EN.
module image_buffer #(
    parameter int IMG_BITS = 904,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                buffer_write_enable,
    input  logic [BYTE_W-1:0]   buffer_data_in,
    input  logic                clear,
    input  logic                img_consume,
    output logic [IMG_BITS-1:0] img_out,
    output logic [ADDR_W-1:0]   write_addr,
    output logic                buffer_full,
    output logic                buffer_empty,
    output logic                overflow,
    output logic [7:0]          checksum
);
    import image_pkg::*;

    buf_state_t          state_q, state_d;
    logic [IMG_BITS-1:0] img_q, img_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                overflow_q, overflow_d;
    logic [BYTE_W-1:0]   byte_rev;
    logic [ADDR_W-1:0]   addr_next;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
    logic [7:0]          checksum_q, checksum_d;
`endif

    // The byte MSB is the earliest pixel, so it lands on the lowest image bit.
    always_comb begin
        byte_rev = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            byte_rev[i] = buffer_data_in[BYTE_W-1-i];
        end
    end

    assign addr_next = addr_q + ADDR_W'(BYTE_W);

    always_comb begin
        state_d    = state_q;
        img_d      = img_q;
        addr_d     = addr_q;
        overflow_d = overflow_q;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        if (clear) begin
            state_d    = BUF_EMPTY;
            img_d      = '0;
            addr_d     = '0;
            overflow_d = 1'b0;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
            checksum_d = 8'h00;
`endif
        end else begin
            case (state_q)
                BUF_EMPTY, BUF_FILLING: begin
                    if (buffer_write_enable) begin
                        img_d[addr_q +: BYTE_W] = byte_rev;
                        addr_d  = addr_next;
                        state_d = (addr_next == ADDR_W'(IMG_BITS)) ? BUF_FULL : BUF_FILLING;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
                        checksum_d = checksum_q + 8'(buffer_data_in);
`endif
                    end
                end
                BUF_FULL: begin
                    // Consume releases the slot but keeps img_out; overflow survives it.
                    if (buffer_write_enable) begin
                        overflow_d = 1'b1;
                    end
                    if (img_consume) begin
                        state_d = BUF_EMPTY;
                        addr_d  = '0;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
                        checksum_d = 8'h00;
`endif
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                    addr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            img_q      <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
            checksum_q <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            img_q      <= img_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
`ifdef IMAGE_BUFFER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    assign img_out      = img_q;
    assign write_addr   = addr_q;
    assign overflow     = overflow_q;
    assign buffer_full  = (state_q == BUF_FULL);
    assign buffer_empty = (state_q == BUF_EMPTY);
`ifdef IMAGE_BUFFER_CHECKSUM_EN
    assign checksum     = checksum_q;
`else
    assign checksum     = 8'h00;
`endif

endmodule
